// File: rtl/nms_pkg.sv
// nms_pkg: shared direction/state types and the non-maximum keep rule for nms_stream.
package nms_pkg;

   localparam int MAG_MAX_W = 32;

   typedef enum logic [1:0] {DIR_0, DIR_45, DIR_90, DIR_135} dir_t;
   typedef enum logic [1:0] {S_FILL, S_RUN, S_FLUSH} state_t;

   // Ties keep the centre; magnitudes are zero-extended to a common width.
   function automatic logic nms_keep(input logic [MAG_MAX_W-1:0] mag,
                                     input logic [MAG_MAX_W-1:0] n0,
                                     input logic [MAG_MAX_W-1:0] n1);
      return (mag >= n0) && (mag >= n1);
   endfunction

endpackage

// File: rtl/nms_stream_if.sv
// nms_stream_if: input/output FIFO handshake bundle of nms_stream.
// edge_count is present only when NMS_EDGE_COUNT_EN is defined.
interface nms_stream_if #(
   parameter int PIXEL_WIDTH = 8
`ifdef NMS_EDGE_COUNT_EN
   , parameter int EC_W = 19
`endif
);
   logic                   in_empty;
   logic                   in_rd_en;
   logic [PIXEL_WIDTH+1:0] in_dout;
   logic                   out_full;
   logic                   out_wr_en;
   logic [PIXEL_WIDTH-1:0] out_din;
   logic                   frame_done;
`ifdef NMS_EDGE_COUNT_EN
   logic [EC_W-1:0]        edge_count;
`endif

   // master: the FIFO side; slave: the NMS core.
   modport master (
      output in_empty, in_dout, out_full,
      input  in_rd_en, out_wr_en, out_din, frame_done
`ifdef NMS_EDGE_COUNT_EN
      , input edge_count
`endif
   );

   modport slave (
      input  in_empty, in_dout, out_full,
      output in_rd_en, out_wr_en, out_din, frame_done
`ifdef NMS_EDGE_COUNT_EN
      , output edge_count
`endif
   );

endinterface

// File: rtl/nms_line_buffer.sv
// nms_line_buffer: WIDTH-deep shift delay line; dout is the sample written WIDTH shifts ago.
module nms_line_buffer #(
   parameter int WIDTH      = 720,
   parameter int DATA_WIDTH = 10
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  en,
   input  logic                  clr,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout
);

   logic [DATA_WIDTH-1:0] taps [WIDTH];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < WIDTH; i++) taps[i] <= '0;
      end else if (clr) begin
         for (int unsigned i = 0; i < WIDTH; i++) taps[i] <= '0;
      end else if (en) begin
         taps[0] <= din;
         for (int unsigned i = 1; i < WIDTH; i++) taps[i] <= taps[i-1];
      end
   end

   assign dout = taps[WIDTH-1];

endmodule

// File: rtl/nms_stream.sv
// nms_stream: streaming 3x3 non-maximum suppression, one thinned pixel out per pixel in.
// Build option: define NMS_EDGE_COUNT_EN to add the per-frame edge_count output.
module nms_stream
   import nms_pkg::*;
#(
   parameter int WIDTH       = 720,
   parameter int HEIGHT      = 540,
   parameter int PIXEL_WIDTH = 8
) (
   input logic         clock,
   input logic         reset,
   nms_stream_if.slave bus
);

   localparam int PW = PIXEL_WIDTH;
   localparam int CW = $clog2(WIDTH);
   localparam int RW = $clog2(HEIGHT);

   state_t        state;
   logic [CW-1:0] in_col, out_col;
   logic [RW-1:0] in_row, out_row;
   logic          accept, write, done, border;
   logic          in_last_col, in_last_row, out_last_col, out_last_row;

   logic [PW+1:0] mid_dout, mid_q1;
   logic [PW-1:0] top_dout, top_q1, top_q2, mid_q2, bot_q1, bot_q2;
   logic [PW-1:0] in_mag, c_mag, n0, n1, nms_val;

   assign in_mag       = bus.in_dout[PW-1:0];
   assign in_last_col  = (in_col == CW'(WIDTH-1));
   assign in_last_row  = (in_row == RW'(HEIGHT-1));
   assign out_last_col = (out_col == CW'(WIDTH-1));
   assign out_last_row = (out_row == RW'(HEIGHT-1));

   // reset is active-low, so handshakes are only granted while it is high.
   always_comb begin
      accept = 1'b0;
      write  = 1'b0;
      if (reset) begin
         unique case (state)
            S_FILL:  accept = !bus.in_empty;
            S_RUN:   begin
               accept = !bus.in_empty && !bus.out_full;
               write  = accept;
            end
            S_FLUSH: write = !bus.out_full;
            default: ;
         endcase
      end
   end

   assign done = (state == S_FLUSH) && write && out_last_row && out_last_col;

   nms_line_buffer #(.WIDTH(WIDTH), .DATA_WIDTH(PW + 2)) u_mid_line (
      .clock (clock),
      .reset (reset),
      .en    (accept),
      .clr   (done),
      .din   (bus.in_dout),
      .dout  (mid_dout)
   );

   nms_line_buffer #(.WIDTH(WIDTH), .DATA_WIDTH(PW)) u_top_line (
      .clock (clock),
      .reset (reset),
      .en    (accept),
      .clr   (done),
      .din   (mid_dout[PW-1:0]),
      .dout  (top_dout)
   );

   // On accepting (r+1,c+1): mid_q1 is centre (r,c); line-buffer outputs are column c+1.
   always_comb begin
      c_mag = mid_q1[PW-1:0];
      n0    = '0;
      n1    = '0;
      unique case (dir_t'(mid_q1[PW+1:PW]))
         DIR_0:   begin n0 = mid_q2;   n1 = mid_dout[PW-1:0]; end
         DIR_45:  begin n0 = top_dout; n1 = bot_q2;           end
         DIR_90:  begin n0 = top_q1;   n1 = bot_q1;           end
         DIR_135: begin n0 = top_q2;   n1 = in_mag;           end
         default: ;
      endcase
      border  = (out_row == '0) || out_last_row || (out_col == '0) || out_last_col;
      nms_val = (!border && nms_keep(MAG_MAX_W'(c_mag), MAG_MAX_W'(n0), MAG_MAX_W'(n1)))
                ? c_mag : '0;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state   <= S_FILL;
         in_col  <= '0;
         in_row  <= '0;
         out_col <= '0;
         out_row <= '0;
         mid_q1  <= '0;
         mid_q2  <= '0;
         top_q1  <= '0;
         top_q2  <= '0;
         bot_q1  <= '0;
         bot_q2  <= '0;
      end else begin
         if (accept) begin
            in_col <= in_last_col ? '0 : in_col + 1'b1;
            if (in_last_col) in_row <= in_last_row ? '0 : in_row + 1'b1;
         end
         if (write) begin
            out_col <= out_last_col ? '0 : out_col + 1'b1;
            if (out_last_col) out_row <= out_last_row ? '0 : out_row + 1'b1;
         end
         if (done) begin
            mid_q1 <= '0;
            mid_q2 <= '0;
            top_q1 <= '0;
            top_q2 <= '0;
            bot_q1 <= '0;
            bot_q2 <= '0;
         end else if (accept) begin
            mid_q1 <= mid_dout;
            mid_q2 <= mid_q1[PW-1:0];
            top_q1 <= top_dout;
            top_q2 <= top_q1;
            bot_q1 <= in_mag;
            bot_q2 <= bot_q1;
         end
         unique case (state)
            S_FILL:  if (accept && in_row == RW'(1) && in_col == '0) state <= S_RUN;
            S_RUN:   if (accept && in_last_row && in_last_col) state <= S_FLUSH;
            S_FLUSH: if (done) state <= S_FILL;
            default: state <= S_FILL;
         endcase
      end
   end

   assign bus.in_rd_en   = accept;
   assign bus.out_wr_en  = write;
   assign bus.out_din    = write ? nms_val : '0;
   assign bus.frame_done = done;

`ifdef NMS_EDGE_COUNT_EN
   localparam int EC_W = $clog2(WIDTH * HEIGHT + 1);

   logic [EC_W-1:0] edge_acc, edge_cnt_q;
   logic            edge_hit;

   assign edge_hit = write && (nms_val != '0);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         edge_acc   <= '0;
         edge_cnt_q <= '0;
      end else if (done) begin
         edge_cnt_q <= edge_acc + EC_W'(edge_hit);
         edge_acc   <= '0;
      end else if (edge_hit) begin
         edge_acc <= edge_acc + 1'b1;
      end
   end

   assign bus.edge_count = edge_cnt_q;
`endif

endmodule

// File: tb/tb_nms_stream.sv
// tb_nms_stream: directed check of nms_stream on an 8x6 frame against a 2-D reference model.
module tb_nms_stream;

   localparam int W = 8;
   localparam int H = 6;
   localparam int N = W * H;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   nms_stream_if #(
      .PIXEL_WIDTH(8)
`ifdef NMS_EDGE_COUNT_EN
      , .EC_W(6)
`endif
   ) bus ();

   nms_stream #(.WIDTH(W), .HEIGHT(H), .PIXEL_WIDTH(8)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      int frame;
      int r;
      int c;
      int exp;
   } vec_t;

   vec_t       vecs [18];
   logic [9:0] img [N];
   logic [9:0] src_q [$];
   logic [7:0] out_q [$];
   logic [7:0] exp_q [$];
   int         fd_idx [$];
   int         ec_q [$];
   int         n_tests = 0;
   int         n_fail = 0;
   int         n_acc = 0;
   int         cyc = 0;
   int         full_lo = -1, full_hi = -1, empty_lo = -1, empty_hi = -1;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int mag_at(input int r, input int c);
      return int'(img[r*W + c][7:0]);
   endfunction

   function automatic logic [7:0] golden(input int r, input int c);
      int m, a, b;
      logic [1:0] d;
      if (r == 0 || r == H-1 || c == 0 || c == W-1) return 8'd0;
      m = mag_at(r, c);
      d = img[r*W + c][9:8];
      case (d)
         2'd0:    begin a = mag_at(r, c-1);   b = mag_at(r, c+1);   end
         2'd1:    begin a = mag_at(r-1, c+1); b = mag_at(r+1, c-1); end
         2'd2:    begin a = mag_at(r-1, c);   b = mag_at(r+1, c);   end
         default: begin a = mag_at(r-1, c-1); b = mag_at(r+1, c+1); end
      endcase
      return (m >= a && m >= b) ? 8'(m) : 8'd0;
   endfunction

   task automatic make_flat(input logic [7:0] mag);
      for (int i = 0; i < N; i++) img[i] = {2'd0, mag};
   endtask

   task automatic make_peak(input logic [1:0] dir);
      for (int i = 0; i < N; i++) img[i] = {dir, 8'd10};
      img[2*W + 3] = {dir, 8'd200};
   endtask

   task automatic make_rand();
      for (int i = 0; i < N; i++) img[i] = 10'($urandom_range(0, 1023));
   endtask

   task automatic load_frame();
      for (int i = 0; i < N; i++) begin
         src_q.push_back(img[i]);
         exp_q.push_back(golden(i / W, i % W));
      end
   endtask

   task automatic step();
      logic rd, wr, fd, st_full, st_empty;
      logic [7:0] od;
      st_full      = (cyc >= full_lo && cyc <= full_hi);
      st_empty     = (cyc >= empty_lo && cyc <= empty_hi);
      bus.out_full = st_full;
      bus.in_empty = st_empty || (src_q.size() == 0);
      bus.in_dout  = (src_q.size() != 0) ? src_q[0] : 10'd0;
      @(negedge clock);
      rd = bus.in_rd_en;
      wr = bus.out_wr_en;
      od = bus.out_din;
      fd = bus.frame_done;
      if (!reset) begin
         check($sformatf("reset in_rd_en c%0d", cyc), int'(rd), 0);
         check($sformatf("reset out_wr_en c%0d", cyc), int'(wr), 0);
         check($sformatf("reset out_din c%0d", cyc), int'(od), 0);
         check($sformatf("reset frame_done c%0d", cyc), int'(fd), 0);
      end
      if (st_full || st_empty)
         check($sformatf("stall in_rd_en c%0d", cyc), int'(rd), 0);
      if (st_full)
         check($sformatf("stall out_wr_en c%0d", cyc), int'(wr), 0);
      @(posedge clock);
      #1;
      if (rd) begin
         void'(src_q.pop_front());
         n_acc++;
      end
      if (wr) begin
         out_q.push_back(od);
         if (fd) fd_idx.push_back(out_q.size());
      end
`ifdef NMS_EDGE_COUNT_EN
      if (fd) ec_q.push_back(int'(bus.edge_count));
`endif
      cyc++;
   endtask

   task automatic run_until(input int n_out, input int budget, input string tag);
      int k;
      k = 0;
      while (out_q.size() < n_out && k < budget) begin
         step();
         k++;
      end
      if (out_q.size() < n_out) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s timeout: got %0d outputs, expected %0d", tag, out_q.size(), n_out);
      end
   endtask

   task automatic compare_all(input string tag);
      check({tag, " output count"}, out_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         check($sformatf("%s pixel %0d", tag, i),
               (i < out_q.size()) ? int'(out_q[i]) : -1, int'(exp_q[i]));
   endtask

   task automatic clear_logs();
      out_q.delete();
      exp_q.delete();
      fd_idx.delete();
      ec_q.delete();
      n_acc = 0;
      cyc = 0;
   endtask

   initial begin
      vecs[0]  = '{0, 0, 0, 0};
      vecs[1]  = '{0, 0, 3, 0};
      vecs[2]  = '{0, 2, 3, 50};
      vecs[3]  = '{0, 5, 7, 0};
      vecs[4]  = '{0, 4, 6, 50};
      vecs[5]  = '{0, 1, 1, 50};
      vecs[6]  = '{1, 2, 3, 200};
      vecs[7]  = '{1, 2, 2, 0};
      vecs[8]  = '{1, 2, 4, 0};
      vecs[9]  = '{1, 1, 3, 10};
      vecs[10] = '{1, 3, 3, 10};
      vecs[11] = '{1, 2, 0, 0};
      vecs[12] = '{2, 2, 3, 200};
      vecs[13] = '{2, 1, 3, 0};
      vecs[14] = '{2, 3, 3, 0};
      vecs[15] = '{2, 2, 2, 10};
      vecs[16] = '{2, 4, 6, 10};
      vecs[17] = '{2, 0, 3, 0};

      bus.in_empty = 1'b1;
      bus.in_dout  = '0;
      bus.out_full = 1'b0;
      reset = 1'b0;

      // Back-to-back frames: flat, peak dir=0, peak dir=2.
      make_flat(8'd50);
      load_frame();
      step();
      step();
      reset = 1'b1;
      make_peak(2'd0);
      load_frame();
      make_peak(2'd2);
      load_frame();
      run_until(3*N, 2000, "three frames");
      compare_all("three frames");
      check("frame_done count", fd_idx.size(), 3);
      for (int i = 0; i < 3; i++)
         check($sformatf("frame_done at write %0d", i),
               (i < fd_idx.size()) ? fd_idx[i] : -1, (i + 1) * N);
      for (int i = 0; i < 18; i++)
         check($sformatf("vec%0d f%0d (%0d,%0d)", i, vecs[i].frame, vecs[i].r, vecs[i].c),
               int'(out_q[vecs[i].frame*N + vecs[i].r*W + vecs[i].c]), vecs[i].exp);
`ifdef NMS_EDGE_COUNT_EN
      check("edge_count samples", ec_q.size(), 3);
      check("edge_count flat", (ec_q.size() > 0) ? ec_q[0] : -1, 24);
      check("edge_count peak dir0", (ec_q.size() > 1) ? ec_q[1] : -1, 22);
      check("edge_count peak dir2", (ec_q.size() > 2) ? ec_q[2] : -1, 22);
`endif

      // Random frame with output-full and input-empty stall windows.
      clear_logs();
      full_lo = 10; full_hi = 14; empty_lo = 20; empty_hi = 22;
      make_rand();
      load_frame();
      run_until(N, 1000, "stall frame");
      compare_all("stall frame");
      check("stall frame_done count", fd_idx.size(), 1);
      full_lo = -1; full_hi = -1; empty_lo = -1; empty_hi = -1;

      // Abort a frame after 20 accepts, then stream a fresh one.
      clear_logs();
      make_rand();
      load_frame();
      while (n_acc < 20 && cyc < 200) step();
      check("accepts before abort", n_acc, 20);
      reset = 1'b0;
      step();
      step();
      reset = 1'b1;
      src_q.delete();
      clear_logs();
      make_rand();
      load_frame();
      run_until(N, 1000, "post-reset frame");
      for (int i = 0; i < 10; i++) step();
      compare_all("post-reset frame");
      check("post-reset frame_done count", fd_idx.size(), 1);
      check("post-reset frame_done pos", (fd_idx.size() > 0) ? fd_idx[0] : -1, N);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
